// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered UART transmitter; define UART_TX_BUF_FIFO_EN for a FIFO_DEPTH FIFO, else a single holding register
module uart_tx_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic [PRESCALE_W-1:0]         PRESCALE,
  output logic                          TX_OUT,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int ENT_W = DATA_WIDTH + 2;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Entry layout: {parity type, parity enable, data}
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [ENT_W-1:0] head;

  // A full buffer refuses the push even when a pop happens in the same cycle.
  assign push       = DATA_VALID && !full;
  assign DATA_READY = !full;

`ifdef UART_TX_BUF_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  assign full       = (level == LVL_W'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign head       = mem[rd_ptr];
  assign FIFO_LEVEL = level;

  // Storage array needs no reset; the level counter defines what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {PAR_TYP, PAR_EN, P_DATA};
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
`else
  logic             hold_valid;
  logic [ENT_W-1:0] hold_data;

  assign full       = hold_valid;
  assign empty      = !hold_valid;
  assign head       = hold_data;
  assign FIFO_LEVEL = {{(LVL_W-1){1'b0}}, hold_valid};

  // Holding register: filled by the bus side, emptied when a frame starts.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= {PAR_TYP, PAR_EN, P_DATA};
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  state_t                  state;
  logic [PRESCALE_W-1:0]   cnt;
  logic [PRESCALE_W-1:0]   presc_r;
  logic [IDX_W-1:0]        bit_idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_bit;
  logic                    par_en_r;
  logic                    tx_out;
  logic                    busy;
  logic                    bit_end;

  assign bit_end = (cnt == '0);
  // A new frame starts from idle, or straight out of the last stop cycle.
  assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign TX_OUT  = tx_out;
  assign Busy    = busy;

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      presc_r  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      par_en_r <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            cnt     <= presc_r;
            bit_idx <= '0;
            tx_out  <= shreg[0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= presc_r;
            if (bit_idx == LAST_IDX) begin
              if (par_en_r) begin
                state  <= S_PARITY;
                tx_out <= par_bit;
              end else begin
                state  <= S_STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx_out  <= shreg[1];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state  <= S_STOP;
            cnt    <= presc_r;
            tx_out <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase

      // Frame start overrides the per-state update; prescale is latched here.
      if (pop) begin
        state    <= S_START;
        cnt      <= PRESCALE;
        presc_r  <= PRESCALE;
        shreg    <= head[DATA_WIDTH-1:0];
        par_en_r <= head[DATA_WIDTH];
        par_bit  <= (^head[DATA_WIDTH-1:0]) ^ head[DATA_WIDTH+1];
        tx_out   <= 1'b0;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - self-checking bench for uart_tx_buf with a queue-based waveform model
module tb_uart_tx_buf;

`ifdef UART_TX_BUF_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] PRESCALE;
  logic       TX_OUT;
  logic       Busy;
  logic [2:0] FIFO_LEVEL;

  uart_tx_buf #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_W(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .Busy(Busy), .FIFO_LEVEL(FIFO_LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       en;
    logic       ty;
  } ent_t;

  // Model: words waiting to be sent, and the line values still to be played.
  ent_t q[$];
  bit   wave[$];

  typedef struct {
    logic [7:0]  d;
    bit          en;
    bit          ty;
    logic [7:0]  p;
    bit          chg;
    int          nb;
    logic [0:10] bits;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit en,
                            input bit ty, input logic [7:0] p);
    bit   do_pop;
    bit   do_push;
    ent_t e;
    bit   etx;
    bit   ebusy;
    if (!r) begin
      q.delete();
      wave.delete();
    end else begin
      do_pop  = (q.size() != 0) && (wave.size() == 0);
      do_push = v && (q.size() < DEPTH);
      if (do_pop) begin
        e = q.pop_front();
        for (int k = 0; k <= int'(p); k++) wave.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int k = 0; k <= int'(p); k++) wave.push_back(e.d[b]);
        if (e.en)
          for (int k = 0; k <= int'(p); k++) wave.push_back((^e.d) ^ e.ty);
        for (int k = 0; k <= int'(p); k++) wave.push_back(1'b1);
      end
      if (do_push) q.push_back({d, en, ty});
    end
    if (wave.size() > 0) begin
      etx   = wave.pop_front();
      ebusy = 1'b1;
    end else begin
      etx   = 1'b1;
      ebusy = 1'b0;
    end
    chk("m_tx", TX_OUT, etx);
    chk("m_busy", Busy, ebusy);
    chk("m_level", FIFO_LEVEL, q.size());
    chk("m_ready", DATA_READY, q.size() < DEPTH);
  endtask

  // One clock: capture the inputs the DUT sees, then check after the edge.
  task automatic tick();
    bit         r, v, en, ty;
    logic [7:0] d, p;
    r  = RST; v = DATA_VALID; d = P_DATA; en = PAR_EN; ty = PAR_TYP; p = PRESCALE;
    @(posedge CLK);
    #1;
    model_step(r, v, d, en, ty, p);
  endtask

  task automatic push_word(input logic [7:0] d, input bit en, input bit ty);
    bit rdy;
    bit done;
    P_DATA = d; PAR_EN = en; PAR_TYP = ty; DATA_VALID = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      rdy = DATA_READY;
      tick();
      if (rdy) done = 1'b1;
    end
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      if (!Busy && FIFO_LEVEL == 0) done = 1'b1;
      else tick();
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int len;
    PRESCALE = v.p;
    push_word(v.d, v.en, v.ty);
    DATA_VALID = 1'b0;
    tick();
    len = v.nb * (int'(v.p) + 1);
    for (int i = 0; i < len; i++) begin
      chk("vec_tx", TX_OUT, v.bits[i / (int'(v.p) + 1)]);
      chk("vec_busy", Busy, 1);
      if (v.chg && i == 5) PRESCALE = 8'd0;
      tick();
    end
    chk("vec_end_busy", Busy, 0);
    chk("vec_end_tx", TX_OUT, 1);
    PRESCALE = 8'd0;
  endtask

  initial begin
    vecs[0] = '{d: 8'b0110_0101, en: 1, ty: 0, p: 8'd0, chg: 0, nb: 11, bits: 11'b01010011001};
    vecs[1] = '{d: 8'b1010_0101, en: 1, ty: 1, p: 8'd0, chg: 0, nb: 11, bits: 11'b01010010111};
    vecs[2] = '{d: 8'b1010_0011, en: 0, ty: 0, p: 8'd0, chg: 0, nb: 10, bits: 11'b01100010110};
    vecs[3] = '{d: 8'hA5,        en: 0, ty: 0, p: 8'd3, chg: 1, nb: 10, bits: 11'b01010010110};

    RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 8'd0;
    tick();
    tick();
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_ready", DATA_READY, 1);
    chk("rst_level", FIFO_LEVEL, 0);
    #2 RST = 1'b1;
    tick();
    tick();

    // Directed frames with known line patterns
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Back-to-back burst of five words: frames must follow with no idle gap
    PRESCALE = 8'd0;
    for (int i = 0; i < 5; i++) push_word(8'h30 + 8'(i), i[0], i[1]);
    chk("burst_level_full", FIFO_LEVEL, DEPTH);
    chk("burst_ready_low", DATA_READY, 0);
    DATA_VALID = 1'b0;
    wait_idle();

    // Reset in the middle of a data bit with words buffered
    PRESCALE = 8'd3;
    push_word(8'h00, 1'b0, 1'b0);
    push_word(8'h11, 1'b1, 1'b0);
    if (DEPTH > 1) push_word(8'h22, 1'b0, 1'b1);
    DATA_VALID = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_tx_low", TX_OUT, 0);
    chk("pre_rst_busy", Busy, 1);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_tx", TX_OUT, 1);
    chk("async_rst_busy", Busy, 0);
    chk("async_rst_level", FIFO_LEVEL, 0);
    tick();
    tick();
    #2 RST = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("post_rst_busy", Busy, 0);
      chk("post_rst_level", FIFO_LEVEL, 0);
    end

    // Randomised traffic with prescale changing while frames are on the line
    for (int n = 0; n < 40; n++) begin
      PRESCALE = 8'($urandom_range(0, 3));
      push_word(8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        DATA_VALID = 1'b0;
        repeat ($urandom_range(0, 12)) tick();
      end
    end
    DATA_VALID = 1'b0;
    wait_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
